dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 45 ++++
 tb/tb_dmem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: two-master data-memory bus between masters, arbiter and a synchronous-read memory
interface dmem_if;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_mem_type, m1_mem_type;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_type;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mem_type,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mem_type, m1_lock, mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_type
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mem_type,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mem_type, m1_lock, mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_type
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/DMA data-memory arbiter with bounded DMA burst lock
module dmem_arbiter #(
  parameter int MAX_LOCK = 8
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt;
  logic          last_gnt, prev_m1, rv0, rv1;
  logic          hold, g0, g1, we;
  always_comb begin
    hold = prev_m1 & bus.m1_lock & bus.m1_req & (lock_cnt < CW'(MAX_LOCK));
    g1   = ~rst & bus.m1_req & (hold | ~bus.m0_req | ~last_gnt);
    g0   = ~rst & bus.m0_req & ~g1;
    we   = g0 ? bus.m0_we : g1 & bus.m1_we;
    bus.m0_gnt    = g0;
    bus.m1_gnt    = g1;
    bus.mem_rd_en = (g0 | g1) & ~we;
    bus.mem_wr_en = (g0 | g1) & we;
    bus.mem_addr  = g0 ? bus.m0_addr : g1 ? bus.m1_addr : '0;
    bus.mem_wdata = g0 ? bus.m0_wdata : g1 ? bus.m1_wdata : '0;
    bus.mem_type  = g0 ? bus.m0_mem_type : g1 ? bus.m1_mem_type : '0;
    bus.m0_rvalid = rv0;
    bus.m1_rvalid = rv1;
    bus.m0_rdata  = bus.mem_rdata;
    bus.m1_rdata  = bus.mem_rdata;
  end
  // last_gnt resets to master 1 so the first tie goes to master 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_gnt <= 1'b1;
      prev_m1  <= 1'b0;
      lock_cnt <= '0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
    end else begin
      if (g0 | g1) last_gnt <= g1;
      prev_m1  <= g1;
      rv0      <= g0 & ~bus.m0_we;
      rv1      <= g1 & ~bus.m1_we;
      lock_cnt <= (g1 & bus.m1_lock) ? ((lock_cnt == CW'(MAX_LOCK)) ? lock_cnt : lock_cnt + 1'b1) : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a transaction-level arbitration and memory model
module tb_dmem_arbiter;
  localparam int MAXL = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_if bus();
  dmem_arbiter #(.MAX_LOCK(MAXL)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        g0, g1, rd, wr, v0, v1;
    logic [31:0] a, d, rdt;
    logic [2:0]  t;
  } exp_t;
  exp_t gq[$];
  int pass = 0;
  int total = 0;
  logic        q0 = 0, w0 = 0, q1 = 0, w1 = 0, lk = 0;
  logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
  logic [2:0]  t0 = 0, t1 = 0;
  int          last = 1, prev = -1, burst = 0, pend = -1;
  logic [31:0] pdata = 0;
  logic [31:0] mm [16];
  logic [31:0] tmem [16];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s actual=%h required=%h", n, act, req);
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    q0 = r; w0 = w; a0 = a; d0 = d; t0 = t;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    q1 = r; w1 = w; a1 = a; d1 = d; t1 = t;
  endtask

  // one bus cycle: apply staged requests, predict the outcome, retire the granted request
  task automatic step(input logic r);
    exp_t e;
    int g;
    logic        we;
    logic [31:0] a;
    @(posedge clk); #1;
    rst = r;
    bus.m0_req = q0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0; bus.m0_mem_type = t0;
    bus.m1_req = q1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1; bus.m1_mem_type = t1;
    bus.m1_lock = lk;
    e = '{default: '0};
    g = -1;
    if (r) begin
      last = 1; prev = -1; burst = 0; pend = -1;
    end else begin
      e.v0 = (pend == 0); e.v1 = (pend == 1); e.rdt = pdata;
      if (q0 && q1) g = (prev == 1 && lk && burst < MAXL) ? 1 : 1 - last;
      else g = q0 ? 0 : q1 ? 1 : -1;
      pend = -1;
      if (g >= 0) begin
        we = (g == 1) ? w1 : w0;
        a  = (g == 1) ? a1 : a0;
        e.g0 = (g == 0); e.g1 = (g == 1); e.rd = !we; e.wr = we; e.a = a;
        e.d  = (g == 1) ? d1 : d0;
        e.t  = (g == 1) ? t1 : t0;
        if (we) mm[a[5:2]] = e.d;
        else begin pend = g; pdata = mm[a[5:2]]; end
        last = g;
      end
      burst = (g == 1 && lk) ? ((burst < MAXL) ? burst + 1 : MAXL) : 0;
      prev = g;
      if (g == 0) q0 = 0;
      if (g == 1) q1 = 0;
    end
    gq.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tmem[i] = i * 32'h01010101;
    tmem[0] = 32'hDEADBEEF;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_wr_en) tmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= tmem[bus.mem_addr[5:2]];
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (gq.size() > 0) begin
        e = gq.pop_front();
        chk("gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'({e.g0, e.g1}));
        chk("strobes", 32'({bus.mem_rd_en, bus.mem_wr_en}), 32'({e.rd, e.wr}));
        chk("mem_addr", bus.mem_addr, e.a);
        chk("mem_wdata", bus.mem_wdata, e.d);
        chk("mem_type", 32'(bus.mem_type), 32'(e.t));
        chk("rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'({e.v0, e.v1}));
        if (e.v0) chk("m0_rdata", bus.m0_rdata, e.rdt);
        if (e.v1) chk("m1_rdata", bus.m1_rdata, e.rdt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mm[i] = i * 32'h01010101;
    mm[0] = 32'hDEADBEEF;
    repeat (3) step(1);
    set0(1, 0, 32'h100, 0, 3'd2);
    step(0);
    step(0);
    step(1);
    for (int i = 0; i < 6; i++) begin
      set0(1, 0, 32'h10 + i * 4, 0, 3'd1);
      set1(1, 0, 32'h20 + i * 4, 0, 3'd4);
      step(0);
    end
    step(1);
    lk = 1;
    for (int i = 0; i < 22; i++) begin
      set0(1, 1, 32'h40 + i * 4, i, 3'd2);
      set1(1, 0, 32'h80 + i * 4, 0, 3'd5);
      step(0);
    end
    q0 = 0;
    for (int i = 0; i < 12; i++) begin
      set1(1, 0, 32'hC0, 0, 3'd0);
      step(0);
    end
    for (int i = 0; i < 3; i++) begin
      set0(1, 0, 32'h4, 0, 3'd3);
      set1(1, 0, 32'h8, 0, 3'd3);
      step(0);
    end
    lk = 0; q0 = 0; q1 = 0;
    step(1);
    set0(1, 0, 32'h300, 0, 3'd2);
    step(0);
    set0(1, 0, 32'h200, 0, 3'd2);
    set1(1, 1, 32'h200, 32'h55, 3'd2);
    step(0);
    step(0);
    step(0);
    set0(1, 0, 32'h100, 0, 3'd2);
    step(0);
    step(1);
    step(1);
    set0(1, 0, 32'h14, 0, 3'd1);
    set1(1, 0, 32'h18, 0, 3'd1);
    step(0);
    step(0);
    step(0);
    for (int n = 0; n < 3000; n++) begin
      if (!q0 && $urandom_range(0, 9) < 6) set0(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom));
      if (!q1 && $urandom_range(0, 9) < 8) set1(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom));
      if ($urandom_range(0, 7) == 0) lk = 1'($urandom_range(0, 1));
      step($urandom_range(0, 99) == 0);
    end
    repeat (3) @(posedge clk);
    if (gq.size() != 0) chk("drain", 32'(gq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
